// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared FSM state encoding and statistics counter width for
//               the FIFO write-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    // Arbiter FSM states: IDLE arbitrates, BURST moves words for one owner
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // Width of each per-requester accepted-word counter
    localparam int STAT_W = 16;

endpackage : fifo_arb_pkg
`default_nettype wire

// File: rtl/fifo_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : fifo_arb_rr_pick
// Description : Combinational rotate-priority finder. Returns the first set
//               bit of req_i searching upward from rr_ptr_i, wrapping mod NREQ.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_arb_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] rr_ptr_i,
    output logic            found_o,
    output logic [IDXW-1:0] idx_o
);

    // Scan from the farthest candidate back toward rr_ptr so the nearest hit wins
    always_comb begin : p_pick
        int              cand;
        logic [IDXW-1:0] cand_idx;
        found_o  = 1'b0;
        idx_o    = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand     = (int'(rr_ptr_i) + k) % NREQ;
            cand_idx = IDXW'(cand);
            if (req_i[cand_idx]) begin
                found_o = 1'b1;
                idx_o   = cand_idx;
            end
        end
    end

endmodule : fifo_arb_rr_pick
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin, burst-capable arbiter sharing one async FIFO
//               write port among NREQ requesters (write-clock domain).
//               Optional macro FIFO_ARB_STATS_EN adds per-requester
//               saturating accepted-word counters (stat_clr / stat_words).
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DWIDTH    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       wclk,
    input  logic                       wrst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*DWIDTH-1:0]     req_data,
    input  logic [NREQ-1:0]            req_last,
    output logic [NREQ-1:0]            req_ready,
    output logic                       fifo_w_en,
    output logic [DWIDTH-1:0]          fifo_wdata,
    input  logic                       fifo_wfull,
    output logic [$clog2(NREQ)-1:0]    grant_id,
    output logic                       busy
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic                       stat_clr,
    output logic [NREQ*STAT_W-1:0]     stat_words
`endif
);

    localparam int              IDXW     = $clog2(NREQ);
    localparam int              CNTW     = $clog2(MAX_BURST + 1);
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(MAX_BURST - 1);
    localparam logic [IDXW-1:0] TOP_IDX  = IDXW'(NREQ - 1);

    arb_state_e      state_q, state_d;
    logic [IDXW-1:0] grant_q, grant_d;
    logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNTW-1:0] burst_cnt_q, burst_cnt_d;

    logic            pick_found;
    logic [IDXW-1:0] pick_idx;
    logic            xfer;
    logic [IDXW-1:0] next_ptr;
    logic [DWIDTH-1:0] data_arr [NREQ];

    // Unflatten the requester data bus so the granted word can be selected by index
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign data_arr[gi] = req_data[gi*DWIDTH +: DWIDTH];
    end

    fifo_arb_rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req_i    (req_valid),
        .rr_ptr_i (rr_ptr_q),
        .found_o  (pick_found),
        .idx_o    (pick_idx)
    );

    // Priority restarts just above whoever was last served
    assign next_ptr = (grant_q == TOP_IDX) ? '0 : grant_q + IDXW'(1);

    // Reset cycle forces every output low even though state only clears at the edge
    assign busy     = (state_q == ST_BURST) & ~wrst;
    assign grant_id = wrst ? '0 : grant_q;

    // Next-state and write-port decode; full stalls the burst without counting
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        xfer        = 1'b0;
        req_ready   = '0;
        fifo_w_en   = 1'b0;
        fifo_wdata  = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d     = pick_idx;
                    burst_cnt_d = '0;
                    state_d     = ST_BURST;
                end
            end
            ST_BURST: begin
                xfer = req_valid[grant_q] & ~fifo_wfull & ~wrst;
                if (xfer) begin
                    fifo_w_en          = 1'b1;
                    fifo_wdata         = data_arr[grant_q];
                    req_ready[grant_q] = 1'b1;
                    burst_cnt_d        = burst_cnt_q + CNTW'(1);
                end
                if ((xfer & (req_last[grant_q] | (burst_cnt_q == LAST_CNT))) |
                    (~req_valid[grant_q] & ~fifo_wfull)) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, grant, round-robin pointer and burst counter registers
    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    for (genvar si = 0; si < NREQ; si++) begin : g_stat
        logic [STAT_W-1:0] words_q;

        // Saturating accepted-word count; clear takes precedence over increment
        always_ff @(posedge wclk) begin
            if (wrst || stat_clr) begin
                words_q <= '0;
            end else if (req_ready[si] && (words_q != STAT_MAX)) begin
                words_q <= words_q + STAT_W'(1);
            end
        end

        assign stat_words[si*STAT_W +: STAT_W] = words_q;
    end
`endif

endmodule : fifo_wr_arbiter
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Self-checking bench for fifo_wr_arbiter (NREQ=4, DWIDTH=8,
//               MAX_BURST=4). Directed scenarios plus randomized traffic,
//               all compared each cycle against a queue-free ownership model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int DWIDTH    = 8;
    localparam int MAX_BURST = 4;

    logic                   wclk = 1'b0;
    logic                   wrst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*DWIDTH-1:0] req_data;
    logic [NREQ-1:0]        req_last;
    logic [NREQ-1:0]        req_ready;
    logic                   fifo_w_en;
    logic [DWIDTH-1:0]      fifo_wdata;
    logic                   fifo_wfull;
    logic [1:0]             grant_id;
    logic                   busy;
`ifdef FIFO_ARB_STATS_EN
    logic                   stat_clr;
    logic [NREQ*16-1:0]     stat_words;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 wclk = ~wclk;

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .DWIDTH    (DWIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .wclk       (wclk),
        .wrst       (wrst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_w_en  (fifo_w_en),
        .fifo_wdata (fifo_wdata),
        .fifo_wfull (fifo_wfull),
        .grant_id   (grant_id),
        .busy       (busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stat_clr   (stat_clr),
        .stat_words (stat_words)
`endif
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: who owns the port, how many words this grant has
    // moved, and where the next search starts. Evaluated on each falling
    // edge from the inputs of that cycle, committed on the rising edge.
    // ------------------------------------------------------------------
    int owner = -1, start_at = 0, last_owner = 0, moved = 0;
    int n_owner, n_start, n_last, n_moved, g, cand;
    bit hit;
    logic [NREQ-1:0]   e_ready;
    logic              e_wen, e_busy;
    logic [DWIDTH-1:0] e_wdata;
    int                e_gid;
`ifdef FIFO_ARB_STATS_EN
    int m_stat [NREQ];
    int n_stat [NREQ];
    bit stat_known = 1'b0;
`endif

    initial begin : p_model
        forever begin
            @(negedge wclk);
            e_ready = '0; e_wen = 1'b0; e_wdata = '0; e_busy = 1'b0; e_gid = 0;
            n_owner = owner; n_start = start_at; n_last = last_owner; n_moved = moved;
            if (wrst) begin
                n_owner = -1; n_start = 0; n_last = 0; n_moved = 0;
            end else if (owner < 0) begin
                e_gid = last_owner;
                hit   = 1'b0;
                for (int k = 0; k < NREQ; k++) begin
                    cand = (start_at + k) % NREQ;
                    if (!hit && req_valid[cand]) begin
                        hit = 1'b1; n_owner = cand; n_last = cand; n_moved = 0;
                    end
                end
            end else begin
                g      = owner;
                e_busy = 1'b1;
                e_gid  = g;
                if (req_valid[g] && !fifo_wfull) begin
                    e_wen      = 1'b1;
                    e_wdata    = req_data[g*DWIDTH +: DWIDTH];
                    e_ready[g] = 1'b1;
                    n_moved    = moved + 1;
                    if (req_last[g] || n_moved == MAX_BURST) begin
                        n_owner = -1; n_start = (g + 1) % NREQ;
                    end
                end else if (!req_valid[g] && !fifo_wfull) begin
                    n_owner = -1; n_start = (g + 1) % NREQ;
                end
            end
            check("model_w_en",   fifo_w_en,  e_wen);
            check("model_wdata",  fifo_wdata, e_wdata);
            check("model_ready",  req_ready,  e_ready);
            check("model_busy",   busy,       e_busy);
            check("model_grant",  grant_id,   e_gid);
`ifdef FIFO_ARB_STATS_EN
            for (int i = 0; i < NREQ; i++) begin
                if (stat_known) check("model_stat", stat_words[i*16 +: 16], m_stat[i]);
                if (wrst || stat_clr)                        n_stat[i] = 0;
                else if (e_ready[i] && m_stat[i] < 65535)    n_stat[i] = m_stat[i] + 1;
                else                                         n_stat[i] = m_stat[i];
            end
`endif
            @(posedge wclk);
            owner = n_owner; start_at = n_start; last_owner = n_last; moved = n_moved;
`ifdef FIFO_ARB_STATS_EN
            for (int i = 0; i < NREQ; i++) m_stat[i] = n_stat[i];
            if (wrst) stat_known = 1'b1;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 2 time units after the rising edge)
    // ------------------------------------------------------------------
    task automatic next_cyc();
        @(posedge wclk);
        #2;
    endtask

    task automatic do_reset();
        wrst = 1'b1; req_valid = '0; req_last = '0; fifo_wfull = 1'b0;
        next_cyc();
        wrst = 1'b0;
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
        req_valid[i] = v;
        req_data[i*DWIDTH +: DWIDTH] = d;
        req_last[i] = l;
    endtask

    task automatic cyc_expect(input string tag, input logic wen, input logic [7:0] wd,
                              input logic [3:0] rdy, input logic b, input int gid);
        @(negedge wclk);
        check({tag, "_w_en"},  fifo_w_en,  wen);
        check({tag, "_wdata"}, fifo_wdata, wd);
        check({tag, "_ready"}, req_ready,  rdy);
        check({tag, "_busy"},  busy,       b);
        check({tag, "_grant"}, grant_id,   gid);
        @(posedge wclk);
        #2;
    endtask

    int              seq   [8];
    int              wc    [8];
    int              rise  [8];
    int              ns;
    logic            prev_busy;
    logic [NREQ-1:0] rdy_s;
    logic [7:0]      dv [NREQ];
    int              acc;

    initial begin : p_stim
        wrst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; fifo_wfull = 1'b0;
`ifdef FIFO_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        next_cyc(); next_cyc(); next_cyc();
        wrst = 1'b0;

        // Reset state, then single requester 1 sending A1,A2,A3 (last on A3)
        cyc_expect("reset", 0, 8'h00, 4'b0000, 0, 0);
        set_req(1, 1, 8'hA1, 0);
        cyc_expect("t1_arb", 0, 8'h00, 4'b0000, 0, 0);
        cyc_expect("t1_w1",  1, 8'hA1, 4'b0010, 1, 1);
        set_req(1, 1, 8'hA2, 0);
        cyc_expect("t1_w2",  1, 8'hA2, 4'b0010, 1, 1);
        set_req(1, 1, 8'hA3, 1);
        cyc_expect("t1_w3",  1, 8'hA3, 4'b0010, 1, 1);
        set_req(1, 0, 8'h00, 0);
        cyc_expect("t1_idle", 0, 8'h00, 4'b0000, 0, 1);

        // All four continuously valid, no last: grants 0,1,2,3,0 of 4 words each
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            dv[i] = 8'(i * 16);
            set_req(i, 1, dv[i], 0);
        end
        ns = 0; prev_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin seq[i] = -1; wc[i] = 0; rise[i] = -1; end
        for (int cyc = 0; cyc < 26; cyc++) begin
            @(negedge wclk);
            if (busy && !prev_busy && ns < 8) begin
                seq[ns] = grant_id; rise[ns] = cyc; ns++;
            end
            if (fifo_w_en && ns > 0) wc[ns-1]++;
            prev_busy = busy;
            rdy_s = req_ready;
`ifdef FIFO_ARB_STATS_EN
            if (cyc == 20)
                for (int i = 0; i < NREQ; i++) check("rr_stat_equal", stat_words[i*16 +: 16], 4);
`endif
            @(posedge wclk);
            #2;
            for (int i = 0; i < NREQ; i++)
                if (rdy_s[i]) begin dv[i] = dv[i] + 8'd1; set_req(i, 1, dv[i], 0); end
        end
        req_valid = '0;
        check("rr_grant_count", ns, 5);
        check("rr_seq0", seq[0], 0);
        check("rr_seq1", seq[1], 1);
        check("rr_seq2", seq[2], 2);
        check("rr_seq3", seq[3], 3);
        check("rr_seq4", seq[4], 0);
        for (int k = 0; k < 5; k++) begin
            check("rr_words", wc[k], 4);
            check("rr_start_cycle", rise[k], 5 * k + 1);
        end
`ifdef FIFO_ARB_STATS_EN
        stat_clr = 1'b1;
        next_cyc();
        stat_clr = 1'b0;
        @(negedge wclk);
        for (int i = 0; i < NREQ; i++) check("stat_clr_zero", stat_words[i*16 +: 16], 0);
        next_cyc();
`endif

        // Requester 2 stalled by 5 full cycles after its 2nd word
        do_reset();
        set_req(2, 1, 8'h20, 0);
        cyc_expect("t3_arb", 0, 8'h00, 4'b0000, 0, 0);
        cyc_expect("t3_w1",  1, 8'h20, 4'b0100, 1, 2);
        set_req(2, 1, 8'h21, 0);
        cyc_expect("t3_w2",  1, 8'h21, 4'b0100, 1, 2);
        set_req(2, 1, 8'h22, 0);
        fifo_wfull = 1'b1;
        for (int k = 0; k < 5; k++) cyc_expect("t3_stall", 0, 8'h00, 4'b0000, 1, 2);
        fifo_wfull = 1'b0;
        cyc_expect("t3_w3",  1, 8'h22, 4'b0100, 1, 2);
        set_req(2, 1, 8'h23, 0);
        cyc_expect("t3_w4",  1, 8'h23, 4'b0100, 1, 2);
        set_req(2, 0, 8'h00, 0);
        cyc_expect("t3_idle", 0, 8'h00, 4'b0000, 0, 2);

        // Reset mid-burst (search pointer is 3 here): re-arbitration must start at 0
        set_req(1, 1, 8'h5A, 0);
        cyc_expect("t5_arb", 0, 8'h00, 4'b0000, 0, 2);
        cyc_expect("t5_w1",  1, 8'h5A, 4'b0010, 1, 1);
        wrst = 1'b1;
        cyc_expect("t5_rst", 0, 8'h00, 4'b0000, 0, 0);
        wrst = 1'b0;
        set_req(0, 1, 8'h0B, 0);
        set_req(3, 1, 8'h3B, 0);
        cyc_expect("t5_post", 0, 8'h00, 4'b0000, 0, 0);
        cyc_expect("t5_g0",   1, 8'h0B, 4'b0001, 1, 0);
        req_valid = '0;
        cyc_expect("t5_rel",  0, 8'h00, 4'b0000, 1, 0);

        // Granted req0 drops valid after one word; req3 is next
        do_reset();
        set_req(0, 1, 8'h0A, 0);
        set_req(3, 1, 8'h3C, 0);
        cyc_expect("t4_arb",  0, 8'h00, 4'b0000, 0, 0);
        cyc_expect("t4_w1",   1, 8'h0A, 4'b0001, 1, 0);
        set_req(0, 0, 8'h00, 0);
        cyc_expect("t4_rel",  0, 8'h00, 4'b0000, 1, 0);
        cyc_expect("t4_arb2", 0, 8'h00, 4'b0000, 0, 0);
        cyc_expect("t4_g3",   1, 8'h3C, 4'b1000, 1, 3);
        req_valid = '0;
        cyc_expect("t4_rel3", 0, 8'h00, 4'b0000, 1, 3);

        // Randomized traffic with full and occasional reset, checked by the model
        rdy_s = '0; acc = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            wrst       = ($urandom_range(0, 299) == 0);
            fifo_wfull = ($urandom_range(0, 99) < 25);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || rdy_s[i])
                    set_req(i, ($urandom_range(0, 99) < 60), 8'($urandom), ($urandom_range(0, 3) == 0));
                else if ($urandom_range(0, 19) == 0)
                    req_valid[i] = 1'b0;
            end
            @(negedge wclk);
            rdy_s = req_ready;
            if (fifo_w_en) acc++;
            @(posedge wclk);
            #2;
        end
        wrst = 1'b0; fifo_wfull = 1'b0;
        check("rand_activity", (acc > 200) ? 1 : 0, 1);

`ifdef FIFO_ARB_STATS_EN
        // Saturation: push enough words through req0 to pass 16'hFFFF
        do_reset();
        req_valid = '0;
        set_req(0, 1, 8'h77, 0);
        acc = 0;
        for (int cyc = 0; cyc < 90000 && acc < 65540; cyc++) begin
            @(negedge wclk);
            if (fifo_w_en) acc++;
            @(posedge wclk);
            #2;
        end
        req_valid = '0;
        check("sat_accepts_reached", acc, 65540);
        @(negedge wclk);
        check("sat_req0", stat_words[15:0], 16'hFFFF);
        check("sat_req1", stat_words[31:16], 0);
        next_cyc();
`endif

        next_cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fifo_wr_arbiter
`default_nettype wire
